// File: rtl/alu_pkg.sv
// Shared ALU control encodings and multiply-sequencer state type.
package alu_pkg;

    localparam int unsigned ALU_CTL_W = 4;

    localparam logic [ALU_CTL_W-1:0] ALU_CTL_AND = 4'b0000;
    localparam logic [ALU_CTL_W-1:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [ALU_CTL_W-1:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [ALU_CTL_W-1:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [ALU_CTL_W-1:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [ALU_CTL_W-1:0] ALU_CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: bit 3 inverts a, bit 2 negates b, bits [1:0] pick AND/OR/ADD/SLT.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [ALU_CTL_W-1:0] alu_ctl,
    output logic [XLEN-1:0]      result,
    output logic                 zero,
    output logic                 overflow
);

    logic [XLEN-1:0] a_op;
    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] sum;

    always_comb begin
        a_op     = alu_ctl[3] ? ~a : a;
        b_op     = alu_ctl[2] ? ~b : b;
        // b-negate doubles as the carry-in so SUB is a + ~b + 1
        sum      = a_op + b_op + XLEN'(alu_ctl[2]);
        overflow = (a_op[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a_op[XLEN-1]);
        case (alu_ctl[1:0])
            2'b00:   result = a_op & b_op;
            2'b01:   result = a_op | b_op;
            2'b10:   result = sum;
            default: result = XLEN'(sum[XLEN-1] ^ overflow);
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_mul_top.sv
// Pairs the shared ALU with the multiply sequencer that drives it.
module alu_mul_top
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] mcand_in,
    input  logic [XLEN-1:0] mplier_in,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [XLEN-1:0] product,
    output logic            busy,
    output logic            alu_zero,
    output logic            alu_overflow
);

    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]      alu_result;

    alu #(.XLEN(XLEN)) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .alu_ctl  (alu_ctl),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    alu_mul_seq #(.XLEN(XLEN)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mcand_in    (mcand_in),
        .mplier_in   (mplier_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .product     (product),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctl     (alu_ctl),
        .alu_result  (alu_result)
    );

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU as its adder.
// Optional `ALU_MUL_SEQ_EARLY_TERM_EN stops RUN once no multiplier bits remain.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [XLEN-1:0]      mcand_in,
    input  logic [XLEN-1:0]      mplier_in,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [XLEN-1:0]      product,
    output logic                 busy,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]      alu_result
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mul_state_t           state_q, state_d;
    logic [XLEN-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic [XLEN-1:0]      mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 early_exit;
    logic                 start_ready_d;
    logic                 done_valid_d;
    logic                 busy_d;
    logic [XLEN-1:0]      alu_a_d;
    logic [XLEN-1:0]      alu_b_d;
    logic [ALU_CTL_W-1:0] alu_ctl_d;

`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
    assign early_exit = ((mplier_q >> 1) == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = mcand_in;
                    mplier_d = mplier_in;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_LAST) || early_exit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_valid && done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        // Product is offered from the second DONE cycle until it is taken
        done_valid_d  = (state_q == DONE) && (state_d == DONE);
        alu_a_d       = (state_d == RUN) ? acc_d   : '0;
        alu_b_d       = (state_d == RUN) ? mcand_d : '0;
        alu_ctl_d     = (state_d == RUN) ? ALU_CTL_ADD : ALU_CTL_AND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctl     <= ALU_CTL_AND;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            start_ready <= start_ready_d;
            done_valid  <= done_valid_d;
            busy        <= busy_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_ctl     <= alu_ctl_d;
        end
    end

    assign product = acc_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq driving a real alu; directed operand vectors.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] mcand_in;
    logic [31:0] mplier_in;
    logic        done_valid;
    logic        done_ready;
    logic [31:0] product;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    always #5 clk = ~clk;

    alu_mul_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mcand_in    (mcand_in),
        .mplier_in   (mplier_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .product     (product),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctl     (alu_ctl),
        .alu_result  (alu_result)
    );

    alu #(.XLEN(32)) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .alu_ctl  (alu_ctl),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    typedef struct {
        logic [31:0] prod;
        int          e0;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic prev_dv = 1'b0;

    // {multiplicand, multiplier, hand-computed low 32 bits of product}
    logic [31:0] vec [0:8][0:2] = '{
        '{32'd3,         32'd5,         32'd15},
        '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001},
        '{32'h00010000,  32'h00010000,  32'h00000000},
        '{32'h00000000,  32'h12345678,  32'h00000000},
        '{32'h12345678,  32'h00000000,  32'h00000000},
        '{32'h80000000,  32'h00000002,  32'h00000000},
        '{32'hFFFFFFFD,  32'h00000007,  32'hFFFFFFEB},
        '{32'h0000FFFF,  32'h0000FFFF,  32'hFFFE0001},
        '{32'd1000,      32'd1000,      32'h000F4240}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] mp);
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
        int hi = -1;
        for (int i = 0; i < 32; i++) if (mp[i]) hi = i;
        return (hi < 0) ? 2 : hi + 2;
`else
        return (mp == mp) ? 33 : 33;
`endif
    endfunction

    // Monitor: checks latency on done_valid rise, product on each handshake
    always @(negedge clk) begin
        #1;
        if (!rst && done_valid && !prev_dv) begin
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else               chk("latency", 32'(cyc - q[0].e0), 32'(q[0].lat));
        end
        if (!rst && done_valid && done_ready && q.size() != 0) begin
            chk("product", product, q[0].prod);
            void'(q.pop_front());
        end
        prev_dv = done_valid;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, "_done_valid"},  32'(done_valid),  32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_product"},     product,          32'd0);
        chk({tag, "_alu_a"},       alu_a,            32'd0);
        chk({tag, "_alu_b"},       alu_b,            32'd0);
        chk({tag, "_alu_ctl"},     32'(alu_ctl),     32'(ALU_CTL_AND));
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [31:0] mc, input logic [31:0] mp, input logic [31:0] prod);
        int   b = 0;
        exp_t e;
        start_valid = 1'b1;
        mcand_in    = mc;
        mplier_in   = mp;
        while (!start_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!start_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            start_valid = 1'b0;
            return;
        end
        e.prod = prod;
        e.e0   = cyc + 1;
        e.lat  = exp_lat(mp);
        q.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
        mcand_in    = '0;
        mplier_in   = '0;
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int b;
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b1;
        mcand_in    = '0;
        mplier_in   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("por");

        for (int i = 0; i < 9; i++) begin
            issue(vec[i][0], vec[i][1], vec[i][2]);
            drain();
        end

        // Back-pressure: product held, new request refused while DONE
        done_ready = 1'b0;
        issue(32'd3, 32'd5, 32'd15);
        b = 0;
        while (!done_valid && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("hold_reach_done", 32'(done_valid), 32'd1);
        start_valid = 1'b1;
        mcand_in    = 32'd6;
        mplier_in   = 32'd7;
        repeat (10) begin
            @(negedge clk);
            chk("hold_product",     product,           32'd15);
            chk("hold_start_ready", 32'(start_ready),  32'd0);
            chk("hold_done_valid",  32'(done_valid),   32'd1);
        end
        done_ready = 1'b1;
        @(negedge clk);
        chk("release_start_ready", 32'(start_ready), 32'd1);
        chk("release_done_valid",  32'(done_valid),  32'd0);
        issue(32'd6, 32'd7, 32'd42);
        drain();

        // Reset in the middle of RUN
        issue(32'd7, 32'd9, 32'd63);
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
        repeat (2) @(negedge clk);
        chk("run_alu_a", alu_a, 32'd7);
        chk("run_alu_b", alu_b, 32'd28);
`else
        repeat (9) @(negedge clk);
        chk("run_alu_a", alu_a, 32'd63);
        chk("run_alu_b", alu_b, 32'd3584);
`endif
        chk("run_busy",    32'(busy),    32'd1);
        chk("run_alu_ctl", 32'(alu_ctl), 32'(ALU_CTL_ADD));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        check_reset("mid_run");
        issue(32'd7, 32'd9, 32'd63);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
